// File: rtl/fp_pkg.sv
// Shared types, flag positions and width helpers for the floating-point add/subtract block.
package fp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_UNPACK,
      S_ALIGN,
      S_ADD,
      S_NORM,
      S_ROUND,
      S_OUT
   } state_t;

   localparam int unsigned FLAG_INVALID   = 3;
   localparam int unsigned FLAG_OVERFLOW  = 2;
   localparam int unsigned FLAG_UNDERFLOW = 1;
   localparam int unsigned FLAG_INEXACT   = 0;

   function automatic int unsigned fp_word_w(input int unsigned exp_w, input int unsigned man_w);
      return 1 + exp_w + man_w;
   endfunction

   // carry, hidden one, fraction, guard, round, sticky
   function automatic int unsigned fp_sig_w(input int unsigned man_w);
      return man_w + 5;
   endfunction

   function automatic int unsigned fp_exp_iw(input int unsigned exp_w);
      return exp_w + 2;
   endfunction

   function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
      logic [63:0] q;
      q = '0;
      for (int unsigned i = 0; i < exp_w; i++) begin
         q = q | (64'd1 << (man_w + i));
      end
      q = q | (64'd1 << (man_w - 1));
      return q;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_bits,
   output logic [CW-1:0]    o_count
);

   localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   // Higher set bits override lower ones, so the last hit is the leading one.
   always_comb begin
      o_count = CW'(WIDTH);
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i_bits[IW'(i)]) o_count = CW'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle floating-point adder/subtractor: round-to-nearest-even, flush-to-zero inputs,
// specials resolved in UNPACK, result held on output_z_stb until output_z_ack.
module fp_addsub
   import fp_pkg::*;
#(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   sel,
   input  logic [EXP_W+MAN_W:0]   input_a,
   input  logic [EXP_W+MAN_W:0]   input_b,
   output logic [EXP_W+MAN_W:0]   output_z,
   output logic                   output_z_stb,
   input  logic                   output_z_ack,
   output logic [3:0]             output_flags
);

   localparam int unsigned W  = fp_word_w(EXP_W, MAN_W);
   localparam int unsigned SW = fp_sig_w(MAN_W);
   localparam int unsigned EW = fp_exp_iw(EXP_W);
   localparam int unsigned CW = $clog2(SW);
   localparam logic [63:0]   QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
   localparam logic [W-1:0]  QNAN      = QNAN_WIDE[W-1:0];
   localparam logic [EW-1:0] EMAX      = {2'b00, {EXP_W{1'b1}}};

   state_t          r_state;
   logic [W-1:0]    r_a, r_b;
   logic            r_sign, r_sub, r_zero;
   logic [EW-1:0]   r_e;
   logic [SW-1:0]   r_ma, r_mb, r_m;
   logic [W-1:0]    r_z;
   logic [3:0]      r_flags;
   logic            r_stb, r_ready;

   assign in_ready     = r_ready;
   assign output_z     = r_z;
   assign output_z_stb = r_stb;
   assign output_flags = r_flags;

   logic [EXP_W-1:0] w_ea, w_eb;
   logic [MAN_W-1:0] w_fa, w_fb;
   logic             w_sa, w_sb;
   logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

   assign w_sa     = r_a[W-1];
   assign w_sb     = r_b[W-1];
   assign w_ea     = r_a[W-2 -: EXP_W];
   assign w_eb     = r_b[W-2 -: EXP_W];
   assign w_fa     = r_a[MAN_W-1:0];
   assign w_fb     = r_b[MAN_W-1:0];
   assign w_a_zero = ~|w_ea;
   assign w_b_zero = ~|w_eb;
   assign w_a_nan  = (&w_ea) & (|w_fa);
   assign w_b_nan  = (&w_eb) & (|w_fb);
   assign w_a_inf  = (&w_ea) & ~(|w_fa);
   assign w_b_inf  = (&w_eb) & ~(|w_fb);

   logic         w_special;
   logic [W-1:0] w_spec_z;
   logic [3:0]   w_spec_f;

   always_comb begin
      w_special = 1'b1;
      w_spec_z  = '0;
      w_spec_f  = '0;
      if (w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa ^ w_sb))) begin
         w_spec_z               = QNAN;
         w_spec_f[FLAG_INVALID] = 1'b1;
      end else if (w_a_inf) begin
         w_spec_z = r_a;
      end else if (w_b_inf) begin
         w_spec_z = r_b;
      end else if (w_a_zero & w_b_zero) begin
         w_spec_z = {w_sa & w_sb, {(W-1){1'b0}}};
      end else if (w_a_zero) begin
         w_spec_z = r_b;
      end else if (w_b_zero) begin
         w_spec_z = r_a;
      end else begin
         w_special = 1'b0;
      end
   end

   // Alignment: larger magnitude first, smaller shifted right with lost bits folded into sticky.
   logic             w_a_ge;
   logic [W-1:0]     w_big, w_small;
   logic [SW-1:0]    w_big_sig, w_small_sig, w_shr, w_mb_al;
   logic [EXP_W-1:0] w_d;
   logic             w_lost;

   assign w_a_ge      = r_a[W-2:0] >= r_b[W-2:0];
   assign w_big       = w_a_ge ? r_a : r_b;
   assign w_small     = w_a_ge ? r_b : r_a;
   assign w_big_sig   = {2'b01, w_big[MAN_W-1:0], 3'b000};
   assign w_small_sig = {2'b01, w_small[MAN_W-1:0], 3'b000};
   assign w_d         = w_big[W-2 -: EXP_W] - w_small[W-2 -: EXP_W];
   assign w_shr       = w_small_sig >> w_d;
   assign w_lost      = |(w_small_sig & ~({SW{1'b1}} << w_d));
   assign w_mb_al     = {w_shr[SW-1:1], w_shr[0] | w_lost};

   logic [SW-1:0] w_sum;
   assign w_sum = r_sub ? (r_ma - r_mb) : (r_ma + r_mb);

   logic [CW-1:0] w_lz;
   logic [SW-1:0] w_norm_m;
   logic [EW-1:0] w_norm_e;

   fp_lzc #(
      .WIDTH (SW - 1),
      .CW    (CW)
   ) u_lzc (
      .i_bits  (r_m[SW-2:0]),
      .o_count (w_lz)
   );

   assign w_norm_m = r_m << w_lz;
   assign w_norm_e = r_e - EW'(w_lz);

   logic             w_g, w_r, w_s, w_up, w_rc, w_ovf, w_unf;
   logic [MAN_W+1:0] w_rm;
   logic [MAN_W-1:0] w_frac;
   logic [EW-1:0]    w_re;
   logic [W-1:0]     w_rnd_z;
   logic [3:0]       w_rnd_f;

   assign w_g    = r_m[2];
   assign w_r    = r_m[1];
   assign w_s    = r_m[0];
   assign w_up   = w_g & (w_r | w_s | r_m[3]);
   assign w_rm   = {1'b0, r_m[SW-2:3]} + {{(MAN_W+1){1'b0}}, w_up};
   assign w_rc   = w_rm[MAN_W+1];
   assign w_frac = w_rc ? w_rm[MAN_W:1] : w_rm[MAN_W-1:0];
   assign w_re   = r_e + {{(EW-1){1'b0}}, w_rc};
   assign w_ovf  = ~w_re[EW-1] & (w_re >= EMAX);
   assign w_unf  = w_re[EW-1] | (w_re == '0);

   always_comb begin
      w_rnd_z = '0;
      w_rnd_f = '0;
      if (r_zero) begin
         w_rnd_z = '0;
      end else if (w_ovf) begin
         w_rnd_z                 = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_rnd_f[FLAG_OVERFLOW]  = 1'b1;
         w_rnd_f[FLAG_INEXACT]   = 1'b1;
      end else if (w_unf) begin
         w_rnd_z                 = {r_sign, {(W-1){1'b0}}};
         w_rnd_f[FLAG_UNDERFLOW] = 1'b1;
         w_rnd_f[FLAG_INEXACT]   = 1'b1;
      end else begin
         w_rnd_z               = {r_sign, w_re[EXP_W-1:0], w_frac};
         w_rnd_f[FLAG_INEXACT] = w_g | w_r | w_s;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ready <= 1'b1;
         r_z     <= '0;
         r_stb   <= 1'b0;
         r_flags <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= input_a;
                  r_b     <= {input_b[W-1] ^ sel, input_b[W-2:0]};
                  r_ready <= 1'b0;
                  r_state <= S_UNPACK;
               end
            end
            S_UNPACK: begin
               if (w_special) begin
                  r_z     <= w_spec_z;
                  r_flags <= w_spec_f;
                  r_stb   <= 1'b1;
                  r_state <= S_OUT;
               end else begin
                  r_state <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               r_ma    <= w_big_sig;
               r_mb    <= w_mb_al;
               r_e     <= {2'b00, w_big[W-2 -: EXP_W]};
               r_sign  <= w_big[W-1];
               r_sub   <= w_sa ^ w_sb;
               r_state <= S_ADD;
            end
            S_ADD: begin
               r_m     <= w_sum;
               r_zero  <= (w_sum == '0);
               r_state <= S_NORM;
            end
            S_NORM: begin
               if (r_m[SW-1]) begin
                  r_m <= {1'b0, r_m[SW-1:2], r_m[1] | r_m[0]};
                  r_e <= r_e + EW'(1);
               end else begin
                  r_m <= w_norm_m;
                  r_e <= w_norm_e;
               end
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               r_z     <= w_rnd_z;
               r_flags <= w_rnd_f;
               r_stb   <= 1'b1;
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (r_stb && output_z_ack) begin
                  r_stb   <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_ready <= 1'b1;
               r_stb   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub.sv
// Scoreboard bench for fp_addsub: single-precision and half-width instances, directed vectors.
module tb_fp_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        v8 = 1'b0, s8 = 1'b0, ack8 = 1'b1;
   logic [31:0] a8 = '0, b8 = '0;
   logic        rdy8, stb8;
   logic [31:0] z8;
   logic [3:0]  f8;

   logic        v5 = 1'b0, s5 = 1'b0, ack5 = 1'b1;
   logic [15:0] a5 = '0, b5 = '0;
   logic        rdy5, stb5;
   logic [15:0] z5;
   logic [3:0]  f5;

   fp_addsub dut8 (
      .clk (clk), .rst (rst), .in_valid (v8), .in_ready (rdy8), .sel (s8),
      .input_a (a8), .input_b (b8), .output_z (z8), .output_z_stb (stb8),
      .output_z_ack (ack8), .output_flags (f8)
   );

   fp_addsub #(.EXP_W(5), .MAN_W(10)) dut5 (
      .clk (clk), .rst (rst), .in_valid (v5), .in_ready (rdy5), .sel (s5),
      .input_a (a5), .input_b (b5), .output_z (z5), .output_z_stb (stb5),
      .output_z_ack (ack5), .output_flags (f5)
   );

   typedef struct {
      string       name;
      logic [31:0] z;
      logic [3:0]  f;
      int          lat;
      int          k;
   } exp_t;

   exp_t q8[$];
   exp_t q5[$];
   exp_t e8, e5;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic seen8 = 1'b0, seen5 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitors: compare once per strobe, at the first falling edge it is seen high.
   always @(negedge clk) begin
      if (rst || !stb8) seen8 = 1'b0;
      else if (!seen8) begin
         seen8 = 1'b1;
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious strobe dut8: got %h expected none", z8);
         end else begin
            e8 = q8.pop_front();
            chk({e8.name, " z"}, z8, e8.z);
            chk({e8.name, " flags"}, {28'h0, f8}, {28'h0, e8.f});
            chk({e8.name, " latency"}, 32'(cyc - e8.k), 32'(e8.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (rst || !stb5) seen5 = 1'b0;
      else if (!seen5) begin
         seen5 = 1'b1;
         if (q5.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious strobe dut5: got %h expected none", z5);
         end else begin
            e5 = q5.pop_front();
            chk({e5.name, " z"}, {16'h0, z5}, e5.z);
            chk({e5.name, " flags"}, {28'h0, f5}, {28'h0, e5.f});
            chk({e5.name, " latency"}, 32'(cyc - e5.k), 32'(e5.lat));
         end
      end
   end

   task automatic issue(input bit half, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] ez, input logic [3:0] ef, input int lat,
                        input string name, input bit push);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!(half ? rdy5 : rdy8) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL %s ready timeout: got 0 expected 1", name);
         return;
      end
      if (half) begin
         a5 = a[15:0]; b5 = b[15:0]; s5 = s; v5 = 1'b1;
      end else begin
         a8 = a; b8 = b; s8 = s; v8 = 1'b1;
      end
      e.name = name; e.z = ez; e.f = ef; e.lat = lat; e.k = cyc + 1;
      if (push) begin
         if (half) q5.push_back(e);
         else      q8.push_back(e);
      end
      @(negedge clk);
      v5 = 1'b0;
      v8 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   int n;
   int stb_seen;

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", {31'h0, rdy8}, 32'h1);
      chk("reset stb", {31'h0, stb8}, 32'h0);
      chk("reset z", z8, 32'h0);
      chk("reset flags", {28'h0, f8}, 32'h0);
      chk("reset in_ready half", {31'h0, rdy5}, 32'h1);

      issue(0, 32'h41a00000, 32'hc1200000, 0, 32'h41200000, 4'b0000, 5, "20+-10", 1);
      issue(0, 32'h42200000, 32'h41f00000, 1, 32'h41200000, 4'b0000, 5, "40-30", 1);
      issue(0, 32'hc2200000, 32'hc1f00000, 0, 32'hc28c0000, 4'b0000, 5, "-40+-30", 1);
      issue(0, 32'h40400000, 32'h40400000, 1, 32'h00000000, 4'b0000, 5, "3-3", 1);
      issue(0, 32'h7f800000, 32'h7f800000, 1, 32'h7fc00000, 4'b1000, 1, "inf-inf", 1);
      issue(0, 32'h7fc00001, 32'h3f800000, 0, 32'h7fc00000, 4'b1000, 1, "nan+1", 1);
      issue(0, 32'h7f7fffff, 32'h7f7fffff, 0, 32'h7f800000, 4'b0101, 5, "max+max", 1);
      issue(0, 32'h3f800000, 32'h33800000, 0, 32'h3f800000, 4'b0001, 5, "tie even down", 1);
      issue(0, 32'h3f800001, 32'h33800000, 0, 32'h3f800002, 4'b0001, 5, "tie even up", 1);
      issue(0, 32'hff800000, 32'h3f800000, 0, 32'hff800000, 4'b0000, 1, "-inf+1", 1);
      issue(0, 32'h00000000, 32'h3f800000, 1, 32'hbf800000, 4'b0000, 1, "0-1", 1);
      issue(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 4'b0000, 1, "-0+-0", 1);
      issue(0, 32'h00000001, 32'h80000000, 0, 32'h00000000, 4'b0000, 1, "denorm+-0", 1);
      issue(0, 32'h00800000, 32'h00c00000, 1, 32'h80000000, 4'b0011, 5, "underflow", 1);
      issue(1, 32'h00003c00, 32'h00003c00, 0, 32'h00004000, 4'b0000, 5, "half 1+1", 1);
      issue(1, 32'h00007bff, 32'h00007bff, 0, 32'h00007c00, 4'b0101, 5, "half max+max", 1);

      // Output held while acknowledge is withheld
      ack8 = 1'b0;
      issue(0, 32'h41a00000, 32'hc1200000, 0, 32'h41200000, 4'b0000, 5, "hold", 1);
      n = 0;
      while (!stb8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("hold stb rises", {31'h0, stb8}, 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("hold z stable", z8, 32'h41200000);
         chk("hold stb stable", {31'h0, stb8}, 32'h1);
         chk("hold in_ready low", {31'h0, rdy8}, 32'h0);
      end
      ack8 = 1'b1;
      @(negedge clk);
      chk("ack stb falls", {31'h0, stb8}, 32'h0);
      chk("ack in_ready", {31'h0, rdy8}, 32'h1);

      // Reset while the operation is in ALIGN abandons it
      issue(0, 32'h41a00000, 32'hc1200000, 0, 32'h41200000, 4'b0000, 5, "abandoned", 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort in_ready", {31'h0, rdy8}, 32'h1);
      chk("abort stb", {31'h0, stb8}, 32'h0);
      stb_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (stb8) stb_seen++;
      end
      chk("abort no strobe", 32'(stb_seen), 32'h0);

      issue(0, 32'h42200000, 32'h41f00000, 1, 32'h41200000, 4'b0000, 5, "after abort", 1);

      n = 0;
      while ((q8.size() != 0 || q5.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("dut8 queue drained", 32'(q8.size()), 32'h0);
      chk("dut5 queue drained", 32'(q5.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
